// File: rtl/ofifo.sv
// ofifo: output FIFO bank between the systolic-array columns and the SFU.
// Each column owns a private first-word-fall-through FIFO. A row (one word
// per column) is released only when every column holds data, so a pop is
// exactly one aligned accumulation step downstream.
//
// Ports:
//   clk      - single clock, rising edge
//   reset    - asynchronous active-high; clears pointers and the overflow flag
//   in[i]    - write data for column i (signed)
//   wr[i]    - push in[i] into FIFO i
//   rd       - pop one aligned row (ignored unless o_valid)
//   out[i]   - head word of FIFO i (meaningful only while o_valid)
//   o_valid  - every FIFO is non-empty
//   o_full   - at least one FIFO holds DEPTH entries
//   o_ready  - ~o_full
//   o_ovf    - sticky: a write to a full FIFO was dropped
module ofifo #(
    parameter int COL   = 8,
    parameter int BW    = 16,
    parameter int DEPTH = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic signed [BW-1:0] in [0:COL-1],
    input  logic [COL-1:0]       wr,
    input  logic                 rd,
    output logic signed [BW-1:0] out [0:COL-1],
    output logic                 o_valid,
    output logic                 o_full,
    output logic                 o_ready,
    output logic                 o_ovf
);

    localparam int AW = $clog2(DEPTH);

    logic [COL-1:0] empty;
    logic [COL-1:0] full;
    logic           pop;

    // Status comes from registered pointers only, so no input reaches an output
    // combinationally.
    assign o_valid = ~|empty;
    assign o_full  = |full;
    assign o_ready = ~o_full;
    assign pop     = rd & o_valid;

    genvar c;
    generate
        for (c = 0; c < COL; c++) begin : g_col
            logic [AW:0]          wr_ptr;
            logic [AW:0]          rd_ptr;
            logic signed [BW-1:0] mem [DEPTH];
            logic                 push;

            // Pointers carry an extra wrap bit: equal -> empty,
            // same slot but opposite wrap -> full.
            assign empty[c] = (wr_ptr == rd_ptr);
            assign full[c]  = (wr_ptr[AW] != rd_ptr[AW]) &&
                              (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
            // Fullness is judged on pre-edge state, so a concurrent pop
            // never makes room for a write to a full column.
            assign push     = wr[c] & ~full[c];

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                end else begin
                    if (push) wr_ptr <= wr_ptr + 1'b1;
                    if (pop)  rd_ptr <= rd_ptr + 1'b1;
                end
            end

            // Storage is data, not control: it is never reset.
            always_ff @(posedge clk) begin
                if (push) mem[wr_ptr[AW-1:0]] <= in[c];
            end

            assign out[c] = mem[rd_ptr[AW-1:0]];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset)              o_ovf <= 1'b0;
        else if (|(wr & full))  o_ovf <= 1'b1;
    end

endmodule

// File: doc/ofifo.md
# ofifo

Output FIFO bank between the 8 systolic-array columns and the SFU accumulator. Each column pushes its 16-bit signed partial sums into a private FIFO whenever that column produces a result. Columns finish at skewed times. The block releases one aligned 8-wide row (one word per column) only when every column has data. Its `out` and `o_valid` drive the SFU's `OFIFO_out` and `valid` inputs directly, so each pop is exactly one SFU accumulation step.

## Interface
- `COL`, default 8: number of columns / FIFOs.
- `BW`, default 16: data width per column, signed.
- `DEPTH`, default 64: entries per column FIFO; power of two, at least 4.

Ports:
- `clk`  in  1: single clock, all state on rising edge.
- `reset`  in  1: asynchronous, active-high; clears all control state.
- `in[0:COL-1]`  in  BW signed: per-column write data.
- `wr`  in  COL: per-column write strobe; bit i pushes `in[i]` into FIFO i.
- `rd`  in  1: pop request for one aligned row.
- `out[0:COL-1]`  out  BW signed: head word of each FIFO (first-word fall-through).
- `o_valid`  out  1: every FIFO is non-empty.
- `o_full`  out  1: at least one FIFO holds DEPTH entries.
- `o_ready`  out  1: equals `~o_full`.
- `o_ovf`  out  1: sticky; a write was dropped.

## Operation
- **Storage and pointers**
  - Each column has a storage array of DEPTH x BW.
  - Each column has a write pointer and a read pointer, each log2(DEPTH)+1 bits wide; the extra MSB is a wrap bit.
  - Count = wr_ptr − rd_ptr, modulo 2^(log2(DEPTH)+1).
  - Empty: pointers equal. Full: low bits equal and MSBs differ.
  - Pointers wrap naturally at 2·DEPTH; there is no special wrap handling.
- **Write**
  - If `wr[i]` is high and FIFO i is not full at the edge, `in[i]` is stored at wr_ptr[i] and wr_ptr[i] increments.
  - Columns are independent; any subset of `wr` may be high in the same cycle.
- **Write to a full column**
  - The word is dropped, the pointer is unchanged, and `o_ovf` is set.
  - This holds even if the same cycle pops: fullness is judged on pre-edge state.
- **Pop**
  - If `rd && o_valid`, all COL read pointers increment together.
- **Invalid pop**
  - `rd` while `!o_valid` is ignored: no pointer moves and it is not an error.
- **Output data**
  - `out[i]` = mem_i[rd_ptr[i]], combinational from registered pointers and storage.
  - The content of `out[i]` for an empty column is don't-care.
  - Checkers sample `out` only when `o_valid` is high.
- **Status flags**
  - `o_valid`, `o_full` and `o_ready` are combinational from the registered pointers only, never from same-cycle `wr`/`rd`.
  - `o_ovf` is a register; only `reset` clears it.
- **Arithmetic**
  - No data arithmetic; words pass through bit-exact, with sign preserved.
- **Reset**
  - All pointers are cleared to 0, giving `o_valid`=0, `o_full`=0, `o_ready`=1 and `o_ovf`=0.
  - Storage is not reset.
  - Reset asserted mid-operation discards all buffered rows immediately, asynchronously.

## Timing
- **Write-to-visible latency:** 1 cycle. A word written at edge N is counted from edge N onward, and `o_valid` can rise in the cycle following edge N.
- **`o_valid` rise:** `o_valid` rises after the edge that writes the last still-empty column.
- **Pop:** a pop at edge N presents the next row on `out` after edge N. With all columns holding ≥2 entries, `rd` held high pops one row per cycle with no bubbles.
- **Combinational paths:** no combinational path from `wr`, `in` or `rd` to any output.
- **Simultaneous write and pop, non-full column:** both take effect and the count is unchanged.
- **Simultaneous write and pop, column with count 1:** the column remains non-empty.
- **Simultaneous write and pop, full column:** the write is dropped and `o_ovf` is set; the pop proceeds.
- **`o_full` / `o_ready` update:** they update the cycle after the edge that changes the count.

## Test plan
1. **Reset:** assert `reset` asynchronously mid-cycle, then release -> immediately `o_valid`=0, `o_full`=0, `o_ready`=1, `o_ovf`=0; `rd`=1 for 5 cycles changes nothing.
2. **Skewed alignment:** `wr[i]` pulses with `in[i]`=100+i at cycle 10+i for i=0..7 -> `o_valid` is low through cycle 17 and high from cycle 18. On `rd`, `out` = {100..107}, then `o_valid` drops.
3. **Signed pass-through and streaming:** push rows {−32768, −1, 0, 1, 32767, 5, −5, 7} and then 3 more rows into all columns, then hold `rd` high -> 4 consecutive pops on consecutive cycles, bit-exact, in FIFO order.
4. **Full and overflow:** write column 3 DEPTH=64 times -> `o_full`=1 and `o_ready`=0. A 65th write to column 3 with simultaneous `rd` (all columns filled) -> the word is dropped, `o_ovf`=1 and stays high until reset.
5. **Pointer wrap:** push and pop 200 rows with random `wr` skew, occupancy ≤ DEPTH -> the output sequence per column matches a scoreboard and `o_ovf` stays 0.
6. **Reset mid-stream:** with 10 rows buffered, pulse `reset` -> `o_valid`=0 at once. Then push one row {1..8} and pop -> `out`={1..8}.
